// File: rtl/keyb_antibounce.sv
// Keypad line debouncer: 2-flop synchroniser + stability FSM, one-clock enable per validated press.
// Optional KEYB_ANTIBOUNCE_LEVEL_OUT_EN adds a registered debounced level output btn_level.
module keyb_antibounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_press_in,
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
  output logic btn_level,
`endif
  output logic enable
);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  // Entering a state already counts one stable sample, so the last sample lands at D-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_pipe;
  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign s = sync_pipe[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], btn_press_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      enable <= 1'b0;
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
      btn_level <= 1'b0;
`endif
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= CONFIRM_PRESS;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CONFIRM_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state  <= PRESSED;
            cnt    <= '0;
            enable <= 1'b1;
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
            btn_level <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= CONFIRM_RELEASE;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CONFIRM_RELEASE: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
            btn_level <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
          btn_level <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keyb_antibounce.sv
// Scoreboard bench for keyb_antibounce: expected pulse times queued at stimulus, popped on each enable.
`timescale 1ns/1ps
module tb_keyb_antibounce;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic enable;
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
  logic btn_level;
`endif

  always #10 clk = ~clk;

  keyb_antibounce #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_press_in (btn),
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
    .btn_level    (btn_level),
`endif
    .enable       (enable)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int q[$];
  int n_chk = 0, n_err = 0, n_pulse = 0, n_exp = 0;

  task automatic chk(string tag, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(logic v, int n);
    btn = v;
    cyc(n);
  endtask

  // Called at a negedge just before the rising drive: first sample is the next
  // posedge k, enable is seen at the negedge after posedge k+D+1.
  task automatic expect_press();
    q.push_back(edge_n + D + 2);
    n_exp++;
  endtask

  always @(negedge clk) begin
    if (reset && enable === 1'b1) begin
      n_pulse++;
      if (q.size() == 0) chk("spurious_pulse", edge_n, -1);
      else               chk("pulse_time", edge_n, q.pop_front());
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
      chk("level_at_pulse", int'(btn_level), 1);
`endif
    end
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn = i[0];
      cyc(1);
      chk("rst_enable", int'(enable), 0);
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
      chk("rst_level", int'(btn_level), 0);
`endif
    end
    btn = 1'b0;
    reset = 1'b1;
    cyc(5);

    // clean press held long: one pulse only
    expect_press();
    drive(1'b1, 1000);
    drive(1'b0, D + 10);
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
    chk("level_idle_1", int'(btn_level), 0);
`endif

    // window boundary: D-1 rejected, D accepted
    drive(1'b1, D - 1);
    drive(1'b0, D + 10);
    expect_press();
    drive(1'b1, D);
    drive(1'b0, D + 10);

    // press bounce, then long hold and long release
    drive(1'b1, 2); drive(1'b0, 3); drive(1'b1, 1);
    drive(1'b0, 4); drive(1'b1, 2); drive(1'b0, 3);
    expect_press();
    drive(1'b1, 60);
    drive(1'b0, 100);

    // release bounce never validates, so no second pulse
    expect_press();
    drive(1'b1, 40);
    drive(1'b0, 5); drive(1'b1, 3); drive(1'b0, 8);
    drive(1'b1, 40);
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
    chk("level_rel_bounce", int'(btn_level), 1);
`endif
    drive(1'b0, D + 10);

    // reset mid-count aborts the press
    drive(1'b1, 8);
    reset = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("midrst_enable", int'(enable), 0);
    end
    reset = 1'b1;
    drive(1'b0, D + 10);

    // repeated bounced presses
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 3); drive(1'b0, 2);
      expect_press();
      drive(1'b1, 30);
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
      chk("level_held", int'(btn_level), 1);
`endif
      drive(1'b0, 2); drive(1'b1, 2);
      drive(1'b0, (p == 0) ? 40 : 60);
`ifdef KEYB_ANTIBOUNCE_LEVEL_OUT_EN
      chk("level_released", int'(btn_level), 0);
`endif
    end

    cyc(5);
    chk("pulse_count", n_pulse, n_exp);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
